// File: rtl/bus_line_arbiter.sv
// Round-robin read-line arbiter: grants the I- or D-cache fill client one
// Sysbus read, gathers the beats into a full line and pulses that client's valid.
module bus_line_arbiter #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       BLOCKSZ        = 512,
  parameter logic [BUS_TAG_WIDTH-1:0] RD_TAG         = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [63:0]               i_addr,
  output logic [BLOCKSZ-1:0]        i_data,
  output logic                      i_valid,
  input  logic                      d_req,
  input  logic [63:0]               d_addr,
  output logic [BLOCKSZ-1:0]        d_data,
  output logic                      d_valid,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int          BEATS     = BLOCKSZ / BUS_DATA_WIDTH;
  localparam int          CNT_W     = $clog2(BEATS);
  localparam logic [63:0] LINE_MASK = ~64'(BLOCKSZ / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [63:0]        line_addr_q, line_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCKSZ-1:0] i_data_q, d_data_q;
  logic [63:0]        req_addr;
  logic [BUS_TAG_WIDTH-1:0] issued_tag;

  assign issued_tag = {RD_TAG[BUS_TAG_WIDTH-1:1], owner_q};
  assign i_data     = i_data_q;
  assign d_data     = d_data_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    line_addr_d  = line_addr_q;
    cnt_d        = cnt_q;
    req_addr     = '0;
    bus_reqcyc   = 1'b0;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    i_valid      = 1'b0;
    d_valid      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the client that did not win last time gets the bus.
          owner_d     = (i_req && d_req) ? ~last_owner_q : d_req;
          req_addr    = owner_d ? d_addr : i_addr;
          line_addr_d = req_addr & LINE_MASK;
          cnt_d       = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = line_addr_q;
        bus_reqtag = issued_tag;
        if (bus_reqack) state_d = S_RESP;
      end
      S_RESP: begin
        bus_respack = bus_respcyc && (bus_resptag == issued_tag);
        if (bus_respack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        i_valid      = ~owner_q;
        d_valid      = owner_q;
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      line_addr_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      line_addr_q  <= line_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Beats land directly in the owner's line; the other client's line is left alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_data_q <= '0;
      d_data_q <= '0;
    end else if (bus_respack) begin
      if (owner_q) d_data_q[cnt_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
      else         i_data_q[cnt_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
    end
  end

endmodule
